ff_bank_exec: RTL and testbench

Bank of WIDTH independently typed flip-flops (D, T, SR, JK) driven by excitation inputs. It is the consumer end of the excitation equations: combinational excitation logic produces D/S/R/T/J/K terms, and this block applies them on each step to produce the next state. The block also flags forbidden SR combinations and counts state-changing steps. It closes the loop for exercising excitation-logic modules in sequential benches.

---
 rtl/ff_bank_exec.sv | 107 ++++++++++
 tb/tb_ff_bank_exec.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank_exec.sv
// Bank of WIDTH independently typed flip-flops (D/T/SR/JK) applying excitation
// terms each step, with sticky SR=11 flags and a saturating change counter.

module ff_bank_cell (
  input  logic [1:0] typ_i,
  input  logic       p_i,
  input  logic       x_i,
  input  logic       cur_i,
  output logic       nxt_o,
  output logic       sr11_o
);
  always_comb begin
    nxt_o  = cur_i;
    sr11_o = 1'b0;
    case (typ_i)
      2'b00: nxt_o = p_i;
      2'b01: nxt_o = cur_i ^ p_i;
      2'b10: begin
        case ({p_i, x_i})
          2'b10:   nxt_o = 1'b1;
          2'b01:   nxt_o = 1'b0;
          2'b11:   sr11_o = 1'b1;  // forbidden: bit holds, flag raised
          default: nxt_o = cur_i;
        endcase
      end
      default: begin
        case ({p_i, x_i})
          2'b10:   nxt_o = 1'b1;
          2'b01:   nxt_o = 1'b0;
          2'b11:   nxt_o = ~cur_i;
          default: nxt_o = cur_i;
        endcase
      end
    endcase
  end
endmodule

module ff_bank_exec #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               step_i,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   load_value_i,
  input  logic [2*WIDTH-1:0] ff_type_i,
  input  logic [WIDTH-1:0]   ex_p_i,
  input  logic [WIDTH-1:0]   ex_q_i,
  input  logic               clear_err_i,
  output logic [WIDTH-1:0]   q_o,
  output logic [WIDTH-1:0]   err_bit_o,
  output logic               sr_err_o,
  output logic [CNT_W-1:0]   change_cnt_o
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d, err_q, err_d, nxt, sr11;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sr_err_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    ff_bank_cell u_cell (
      .typ_i  (ff_type_i[2*g +: 2]),
      .p_i    (ex_p_i[g]),
      .x_i    (ex_q_i[g]),
      .cur_i  (q_q[g]),
      .nxt_o  (nxt[g]),
      .sr11_o (sr11[g])
    );
  end

  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (load_i) begin
      q_d = load_value_i;
    end else begin
      if (clear_err_i) err_d = '0;
      if (step_i) begin
        q_d   = nxt;
        err_d = err_d | sr11;  // new errors win over clear
        if ((nxt != q_q) && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q_q      <= '0;
      err_q    <= '0;
      sr_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      q_q      <= q_d;
      err_q    <= err_d;
      sr_err_q <= |err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q_o          = q_q;
  assign err_bit_o    = err_q;
  assign sr_err_o     = sr_err_q;
  assign change_cnt_o = cnt_q;
endmodule

// File: tb/tb_ff_bank_exec.sv
// Directed bench for ff_bank_exec: one task per scenario, hand-computed expectations.

module tb_ff_bank_exec;
  localparam int W = 4;
  localparam int C = 8;

  logic           clk = 1'b0;
  logic           reset, step, load, clear_err;
  logic [W-1:0]   load_value, ex_p, ex_q;
  logic [2*W-1:0] ff_type;
  logic [W-1:0]   q, err_bit;
  logic           sr_err;
  logic [C-1:0]   change_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ff_bank_exec #(.WIDTH(W), .CNT_W(C)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .step_i       (step),
    .load_i       (load),
    .load_value_i (load_value),
    .ff_type_i    (ff_type),
    .ex_p_i       (ex_p),
    .ex_q_i       (ex_q),
    .clear_err_i  (clear_err),
    .q_o          (q),
    .err_bit_o    (err_bit),
    .sr_err_o     (sr_err),
    .change_cnt_o (change_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step = 0; load = 0; clear_err = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    #3;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    idle(); load = 1; load_value = v;
    tick();
    idle();
  endtask

  task automatic test_reset();
    ff_type = '0; ex_p = '0; ex_q = '0; load_value = '0;
    do_reset();
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_q got %b want 0000", q); end
    checks++; if (change_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", change_cnt); end
    checks++; if (sr_err !== 1'b0) begin errors++; $display("FAIL reset_sr_err got %b want 0", sr_err); end
    checks++; if (err_bit !== 4'b0000) begin errors++; $display("FAIL reset_err_bit got %b want 0000", err_bit); end
  endtask

  task automatic test_load();
    do_load(4'b1010);
    checks++; if (q !== 4'b1010) begin errors++; $display("FAIL load_q got %b want 1010", q); end
    checks++; if (change_cnt !== 8'd0) begin errors++; $display("FAIL load_cnt got %0d want 0", change_cnt); end
  endtask

  task automatic test_d_step();
    ff_type = 8'h00; ex_p = 4'b0101; ex_q = 4'b1111; step = 1;
    tick();
    checks++; if (q !== 4'b0101) begin errors++; $display("FAIL d_q1 got %b want 0101", q); end
    checks++; if (change_cnt !== 8'd1) begin errors++; $display("FAIL d_cnt1 got %0d want 1", change_cnt); end
    tick();
    idle();
    checks++; if (q !== 4'b0101) begin errors++; $display("FAIL d_q2 got %b want 0101", q); end
    checks++; if (change_cnt !== 8'd1) begin errors++; $display("FAIL d_cnt2 got %0d want 1", change_cnt); end
    tick();
    checks++; if (q !== 4'b0101) begin errors++; $display("FAIL d_hold got %b want 0101", q); end
  endtask

  task automatic test_t_jk();
    logic [W-1:0] exp_q [3];
    exp_q[0] = 4'b1111; exp_q[1] = 4'b0000; exp_q[2] = 4'b1111;
    do_reset();
    ff_type = 8'h55; ex_p = 4'b1111; ex_q = 4'b0000; step = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL t_q%0d got %b want %b", i, q, exp_q[i]); end
    end
    checks++; if (change_cnt !== 8'd3) begin errors++; $display("FAIL t_cnt got %0d want 3", change_cnt); end
    ff_type = 8'hFF; ex_p = 4'b1111; ex_q = 4'b1111;
    tick();
    idle();
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL jk_q got %b want 0000", q); end
    checks++; if (change_cnt !== 8'd4) begin errors++; $display("FAIL jk_cnt got %0d want 4", change_cnt); end
  endtask

  task automatic test_mixed();
    // bit3 D, bit2 T, bit1 SR, bit0 JK
    do_load(4'b0000);
    ff_type = 8'b00_01_10_11; ex_p = 4'b1111; ex_q = 4'b0000; step = 1;
    tick();
    checks++; if (q !== 4'b1111) begin errors++; $display("FAIL mix_q1 got %b want 1111", q); end
    ex_p = 4'b0010; ex_q = 4'b0001;
    tick();
    idle();
    checks++; if (q !== 4'b0110) begin errors++; $display("FAIL mix_q2 got %b want 0110", q); end
  endtask

  task automatic test_sr_err();
    do_load(4'b0000);
    ff_type = 8'hAA; ex_p = 4'b0100; ex_q = 4'b0100; step = 1;
    tick();
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL sr_q got %b want 0000", q); end
    checks++; if (err_bit !== 4'b0100) begin errors++; $display("FAIL sr_err_bit got %b want 0100", err_bit); end
    checks++; if (sr_err !== 1'b1) begin errors++; $display("FAIL sr_err1 got %b want 1", sr_err); end
    ex_p = 4'b0001; ex_q = 4'b0001; clear_err = 1;
    tick();
    checks++; if (err_bit !== 4'b0001) begin errors++; $display("FAIL sr_setwins got %b want 0001", err_bit); end
    checks++; if (sr_err !== 1'b1) begin errors++; $display("FAIL sr_err2 got %b want 1", sr_err); end
    idle();
    tick();
    checks++; if (err_bit !== 4'b0001) begin errors++; $display("FAIL sr_sticky got %b want 0001", err_bit); end
    clear_err = 1;
    tick();
    idle();
    checks++; if (err_bit !== 4'b0000) begin errors++; $display("FAIL sr_clear got %b want 0000", err_bit); end
    checks++; if (sr_err !== 1'b0) begin errors++; $display("FAIL sr_err3 got %b want 0", sr_err); end
  endtask

  task automatic test_priority();
    do_reset();
    load = 1; step = 1; load_value = 4'b0110;
    ff_type = 8'hAA; ex_p = 4'b1111; ex_q = 4'b1111;
    tick();
    checks++; if (q !== 4'b0110) begin errors++; $display("FAIL prio_q got %b want 0110", q); end
    checks++; if (err_bit !== 4'b0000) begin errors++; $display("FAIL prio_err got %b want 0000", err_bit); end
    ff_type = 8'h55; load_value = 4'b1001;
    tick();
    idle();
    checks++; if (q !== 4'b1001) begin errors++; $display("FAIL prio_tq got %b want 1001", q); end
    checks++; if (change_cnt !== 8'd0) begin errors++; $display("FAIL prio_cnt got %0d want 0", change_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    ff_type = 8'h55; ex_p = 4'b0001; ex_q = 4'b0000; step = 1;
    for (int i = 0; i < 254; i++) tick();
    checks++; if (change_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", change_cnt); end
    for (int i = 0; i < 46; i++) tick();
    idle();
    checks++; if (change_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", change_cnt); end
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL sat_q got %b want 0000", q); end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_load(4'b1010);
    ff_type = 8'h55; ex_p = 4'b0001; step = 1;
    tick();
    ff_type = 8'hAA; ex_p = 4'b0010; ex_q = 4'b0010;
    tick();
    idle();
    checks++; if (q !== 4'b1011 || err_bit !== 4'b0010 || change_cnt !== 8'd1)
      begin errors++; $display("FAIL ar_pre got q=%b err=%b cnt=%0d want 1011 0010 1", q, err_bit, change_cnt); end
    #2 reset = 1;
    #1;
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL ar_q got %b want 0000", q); end
    checks++; if (err_bit !== 4'b0000) begin errors++; $display("FAIL ar_err got %b want 0000", err_bit); end
    checks++; if (change_cnt !== 8'd0) begin errors++; $display("FAIL ar_cnt got %0d want 0", change_cnt); end
    checks++; if (sr_err !== 1'b0) begin errors++; $display("FAIL ar_sr got %b want 0", sr_err); end
    @(negedge clk);
    reset = 0;
    ff_type = 8'h55; ex_p = 4'b0011; step = 1;
    tick();
    idle();
    checks++; if (q !== 4'b0011) begin errors++; $display("FAIL ar_first got %b want 0011", q); end
  endtask

  initial begin
    reset = 1; idle();
    test_reset();
    test_load();
    test_d_step();
    test_t_jk();
    test_mixed();
    test_sr_err();
    test_priority();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
